// File: rtl/cic_comp_fir.sv
// CIC compensation FIR: decimate-by-DECIM, one serial multiply-accumulate
// per tap, rounded and saturated output, runtime-loadable coefficients.
module cic_comp_fir #(
    parameter int IN_WIDTH   = 50,
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 16,
    parameter int NTAPS      = 32,
    parameter int DECIM      = 2,
    parameter int OUT_WIDTH  = 24,
    parameter int OUT_SHIFT  = 15,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NTAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [IN_WIDTH-1:0]   in_data,
    input  logic                         coef_we,
    input  logic [$clog2(NTAPS)-1:0]     coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         out_valid,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         busy,
    output logic                         overrun
);

    localparam int AW = $clog2(NTAPS);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PD = DATA_WIDTH + COEF_WIDTH;
    localparam int AX = ACC_WIDTH + 1;

    localparam logic signed [AX-1:0] RND     = AX'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [AX-1:0] SAT_MAX = (AX'(1) <<< (OUT_WIDTH - 1)) - AX'(1);
    localparam logic signed [AX-1:0] SAT_MIN = -SAT_MAX - AX'(1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0] x_mem [NTAPS];
    logic signed [COEF_WIDTH-1:0] c_mem [NTAPS];

    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              base;
    logic [AW-1:0]              k;
    logic [AW-1:0]              rd_idx;
    logic [PW-1:0]              phase;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [PD-1:0]       prod;
    logic signed [AX-1:0]       rnd;
    logic signed [AX-1:0]       shr;
    logic signed [OUT_WIDTH-1:0] sat;
    logic                       accept;
    logic                       trigger;
    logic                       unused_low;

    // Only the top DATA_WIDTH bits of the CIC word are kept.
    assign unused_low = ^in_data[IN_WIDTH-DATA_WIDTH-1:0];

    assign busy    = (state != IDLE);
    assign accept  = in_valid && (state == IDLE);
    assign trigger = accept && (phase == PW'(DECIM - 1));
    assign rd_idx  = base - k;
    assign prod    = c_mem[k] * x_mem[rd_idx];

    always_comb begin
        rnd = AX'(acc) + RND;
        shr = rnd >>> OUT_SHIFT;
        sat = shr[OUT_WIDTH-1:0];
        if (shr > SAT_MAX) begin
            sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shr < SAT_MIN) begin
            sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (trigger) state_nx = MAC;
            MAC:  if (k == AW'(NTAPS - 1)) state_nx = OUT;
            OUT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                x_mem[i] <= '0;
                c_mem[i] <= '0;
            end
            wr_ptr    <= '0;
            base      <= '0;
            k         <= '0;
            phase     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && busy) begin
                overrun <= 1'b1;
            end
            if (coef_we && !busy) begin
                c_mem[coef_addr] <= coef_data;
            end
            if (accept) begin
                x_mem[wr_ptr] <= in_data[IN_WIDTH-1 -: DATA_WIDTH];
                wr_ptr        <= wr_ptr + AW'(1);
                phase         <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
            end
            if (trigger) begin
                base <= wr_ptr;
                acc  <= '0;
                k    <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_WIDTH'(prod);
                k   <= k + AW'(1);
            end
            if (state == OUT) begin
                out_data  <= sat;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir with a reference convolution model
// and an expected-output queue checked on every out_valid pulse.
module tb_cic_comp_fir;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [49:0] in_data;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               out_valid;
    logic signed [23:0] out_data;
    logic               busy;
    logic               overrun;

    int total = 0;
    int fails = 0;

    longint             hist [32];
    logic signed [15:0] cm [32];
    int                 wp;
    int                 ph;
    longint             exp_q [$];

    cic_comp_fir dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_out(input int b);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            acc += longint'(cm[i]) * hist[(b - i + 32) % 32];
        end
        r = (acc + 16384) >>> 15;
        if (r > 8388607) r = 8388607;
        if (r < -8388608) r = -8388608;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            hist[i] = 0;
            cm[i]   = '0;
        end
        wp = 0;
        ph = 0;
        exp_q.delete();
    endtask

    // mode 0: push expected and wait out the MAC; 1: push, no wait; 2: neither
    task automatic feed(input longint x, input int mode);
        logic signed [23:0] xs;
        int b;
        bit trig;
        xs       = x[23:0];
        in_valid = 1'b1;
        in_data  = {xs, 26'd0};
        hist[wp] = longint'(xs);
        b        = wp;
        wp       = (wp + 1) % 32;
        trig     = (ph == 1);
        ph       = (ph + 1) % 2;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        if (trig && mode != 2) exp_q.push_back(model_out(b));
        if (trig && mode == 0) repeat (33) @(negedge clk);
    endtask

    task automatic wcoef(input int a, input longint v, input bit apply);
        coef_we   = 1'b1;
        coef_addr = a[4:0];
        coef_data = v[15:0];
        @(negedge clk);
        coef_we = 1'b0;
        if (apply) cm[a] = v[15:0];
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_spurious", out_valid, 0);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // impulse response
        for (int i = 0; i < 32; i++) wcoef(i, 1024 * (i + 1), 1);
        feed(32768, 0);
        for (int i = 0; i < 33; i++) feed(0, 0);

        // rounding at the half-LSB boundary
        for (int i = 0; i < 32; i++) wcoef(i, (i == 0) ? 1 : 0, 1);
        feed(0, 0); feed(16384, 0);
        feed(0, 0); feed(16383, 0);
        feed(0, 0); feed(-16384, 0);
        feed(0, 0); feed(-16385, 0);

        // saturation both ways
        for (int i = 0; i < 32; i++) wcoef(i, 32767, 1);
        for (int i = 0; i < 34; i++) feed(8388607, 0);
        for (int i = 0; i < 34; i++) feed(-8388608, 0);
        chk("overrun_clean", overrun, 0);

        // timing, drop and coefficient writes around a busy window
        for (int i = 0; i < 32; i++) wcoef(i, (i == 0) ? 8192 : 0, 1);
        feed(1000, 0);
        feed(2000, 1);
        chk("busy_e0", busy, 1);
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        in_data  = {24'sd777, 26'd0};
        @(negedge clk);
        in_valid = 1'b0;
        chk("overrun_e5", overrun, 1);
        repeat (4) @(negedge clk);
        wcoef(1, 32767, 0);
        repeat (22) @(negedge clk);
        chk("busy_e32", busy, 1);
        chk("ovalid_e32", out_valid, 0);
        @(negedge clk);
        chk("ovalid_e33", out_valid, 1);
        chk("busy_e33", busy, 0);
        @(negedge clk);
        chk("ovalid_e34", out_valid, 0);
        repeat (5) @(negedge clk);
        wcoef(0, 16384, 1);
        feed(3000, 0);
        feed(4000, 0);
        chk("overrun_sticky", overrun, 1);

        // reset in the middle of a MAC
        for (int i = 0; i < 32; i++) wcoef(i, 1000 + i, 1);
        feed(5000, 0);
        feed(6000, 2);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_out_data", out_data, 0);
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_ovalid", seen, 0);

        // coefficients were cleared: impulse gives zeros
        feed(32768, 0);
        for (int i = 0; i < 5; i++) feed(0, 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
